alsu_driver: RTL and testbench
==============================

ALSU_DRIVER -- requirements
Module: alsu_driver

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning ALSU input-to-output register latency in cycles.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command FIFO not full.
REQ-007 SHALL have port cmd_data  input  16  {opcode[2:0], A[2:0], B[2:0], cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}, MSB first.
REQ-008 SHALL have ports opcode (3), A (3), B (3), cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction (1 each), all outputs, all registered, driving the ALSU inputs.
REQ-009 SHALL have port alsu_out  input  6  ALSU result.
REQ-010 SHALL have port alsu_leds  input  16  ALSU invalid indicator.
REQ-011 SHALL have port rsp_valid  output  1  result available.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-013 SHALL have port rsp_out  output  6  captured ALSU result.
REQ-014 SHALL have port rsp_invalid  output  1  captured alsu_leds != 0.

Function
REQ-015 SHALL accept a command on any edge where cmd_valid && cmd_ready; cmd_ready = (FIFO count < FIFO_DEPTH), independent of cmd_valid.
REQ-016 SHALL implement the FIFO with wrapping read/write pointers; simultaneous push and pop while full SHALL be disallowed (cmd_ready low), while empty push only.
REQ-017 SHALL use FSM states IDLE, WAIT, RESP.
REQ-018 IDLE: on an edge with FIFO non-empty, SHALL pop the head, load all drive outputs from it, load wait counter with LATENCY, go WAIT.
REQ-019 WAIT: SHALL hold drive outputs unchanged, decrement counter each edge; on the edge where counter == 0, SHALL capture alsu_out into rsp_out and (alsu_leds != 0) into rsp_invalid, set rsp_valid, go RESP.
REQ-020 Capture edge SHALL therefore be LATENCY+1 edges after the load edge (edge 3 for LATENCY=2).
REQ-021 RESP: rsp_valid, rsp_out, rsp_invalid SHALL stay stable until an edge with rsp_ready high; on that edge rsp_valid clears and state goes IDLE.
REQ-022 No pop from IDLE on the same edge as RESP handshake; next command loads one edge later (minimum 1 idle cycle between commands).
REQ-023 Drive outputs SHALL hold the last command in IDLE and RESP; subsequent ALSU activity (e.g. shift/rotate) SHALL NOT affect the captured rsp_out.
REQ-024 FIFO SHALL continue accepting commands in every FSM state.

Reset
REQ-025 On an edge with rst high: FIFO emptied, state IDLE, counter 0, all drive outputs 0, rsp_valid 0, rsp_out 0, rsp_invalid 0; cmd_ready is 1 after that edge.
REQ-026 Reset SHALL override any concurrent push, pop or handshake, including mid-WAIT or mid-RESP; the in-flight command is discarded.

Verification
REQ-027 OR: cmd opcode=0, A=1, B=2, others 0 -> drive outputs set at edge 1, rsp_valid at edge 4, rsp_out=3, rsp_invalid=0.
REQ-028 ADD: opcode=2, A=1, B=2, cin=1, rsp_ready held high -> rsp_out=4, rsp_valid high exactly 1 cycle.
REQ-029 Invalid: opcode=6, A=1, B=1 -> rsp_out=0, rsp_invalid=1; then MUL opcode=3, A=2, B=3 -> rsp_out=6, rsp_invalid=0.
REQ-030 Backpressure/full: rsp_ready=0, push 6 commands back-to-back -> 5 accepted (1 popped + 4 queued), cmd_ready low from then on, rsp values stable; release rsp_ready -> all 5 responses in order.
REQ-031 Reset mid-WAIT: assert rst 1 cycle at edge 2 after load -> no rsp_valid, all drive outputs 0, cmd_ready 1, next command completes normally.

Source files
------------

// File: rtl/alsu_driver.sv
// Command-queued driver for a pipelined ALSU: pops 16-bit commands, holds them on the ALSU
// inputs and returns the captured result through a valid/ready response port.
module alsu_driver #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic [2:0]  opcode,
  output logic [2:0]  A,
  output logic [2:0]  B,
  output logic        cin,
  output logic        serial_in,
  output logic        red_op_A,
  output logic        red_op_B,
  output logic        bypass_A,
  output logic        bypass_B,
  output logic        direction,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_out,
  output logic        rsp_invalid
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [PtrW:0]   DepthL = FIFO_DEPTH[PtrW:0];
  localparam logic [CntW-1:0] LatL   = LATENCY[CntW-1:0];

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_t;

  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;

  state_t          r_state;
  logic [CntW-1:0] r_cnt;
  logic [15:0]     r_drive;
  logic            r_rsp_valid;
  logic [5:0]      r_rsp_out;
  logic            r_rsp_invalid;

  logic            w_push;
  logic            w_pop;

  assign cmd_ready = (r_count < DepthL);
  assign w_push    = cmd_valid && cmd_ready;
  // Pop only from idle, so a response handshake always costs one idle edge before the next load.
  assign w_pop     = (r_state == StIdle) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_drive       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_out     <= '0;
      r_rsp_invalid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_drive <= r_mem[r_rd_ptr];
            r_cnt   <= LatL;
            r_state <= StWait;
          end
        end
        StWait: begin
          // Counter reaches zero LATENCY edges after load; capture on the following edge.
          if (r_cnt == '0) begin
            r_rsp_out     <= alsu_out;
            r_rsp_invalid <= |alsu_leds;
            r_rsp_valid   <= 1'b1;
            r_state       <= StResp;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign {opcode, A, B, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction} =
      r_drive;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_out     = r_rsp_out;
  assign rsp_invalid = r_rsp_invalid;

endmodule

// File: tb/tb_alsu_driver.sv
// Bench for alsu_driver: behavioural pipelined ALSU, directed scenarios plus random traffic,
// with a queue-based scoreboard checked on every response handshake.
module tb_alsu_driver;

  localparam int unsigned LATENCY    = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [2:0]  drv_op, drv_a, drv_b;
  logic        drv_cin, drv_sin, drv_ra, drv_rb, drv_ba, drv_bb, drv_dir;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [5:0]  rsp_out;
  logic        rsp_invalid;
  logic [15:0] drive;

  int total = 0;
  int bad   = 0;
  int rsp_seen = 0;
  logic [15:0] exp_q[$];

  alsu_driver #(
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .opcode     (drv_op),
    .A          (drv_a),
    .B          (drv_b),
    .cin        (drv_cin),
    .serial_in  (drv_sin),
    .red_op_A   (drv_ra),
    .red_op_B   (drv_rb),
    .bypass_A   (drv_ba),
    .bypass_B   (drv_bb),
    .direction  (drv_dir),
    .alsu_out   (alsu_out),
    .alsu_leds  (alsu_leds),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_invalid(rsp_invalid)
  );

  always #5 clk = ~clk;

  assign drive = {drv_op, drv_a, drv_b, drv_cin, drv_sin, drv_ra, drv_rb, drv_ba, drv_bb, drv_dir};

  // Behavioural ALSU result for a command word: {invalid, out[5:0]}.
  function automatic logic [6:0] alsu_fn(input logic [15:0] c);
    logic [2:0] op, a, b;
    logic [5:0] ab, res;
    op = c[15:13];
    a  = c[12:10];
    b  = c[9:7];
    ab = {a, b};
    if (op inside {3'd6, 3'd7} || ((c[4] || c[3]) && op >= 3'd2)) return {1'b1, 6'd0};
    if (c[2]) return {1'b0, 3'd0, a};
    if (c[1]) return {1'b0, 3'd0, b};
    case (op)
      3'd0:    res = c[4] ? {5'd0, |a} : (c[3] ? {5'd0, |b} : {3'd0, a | b});
      3'd1:    res = c[4] ? {5'd0, ^a} : (c[3] ? {5'd0, ^b} : {3'd0, a ^ b});
      3'd2:    res = 6'(a) + 6'(b) + 6'(c[6]);
      3'd3:    res = 6'(a) * 6'(b);
      3'd4:    res = c[0] ? {ab[4:0], c[5]} : {c[5], ab[5:1]};
      default: res = c[0] ? {ab[4:0], ab[5]} : {ab[0], ab[5:1]};
    endcase
    return {1'b0, res};
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic [6:0] rest);
    return {op, a, b, rest};
  endfunction

  // ALSU model: result of the driven inputs, delayed by LATENCY registers.
  logic [6:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= alsu_fn(drive);
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign alsu_out  = pipe[LATENCY-1][5:0];
  assign alsu_leds = {16{pipe[LATENCY-1][6]}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: records accepted commands, checks every response handshake.
  initial begin
    logic       stall = 1'b0;
    logic       after_hs = 1'b0;
    logic [5:0] stall_out = '0;
    logic       stall_inv = 1'b0;
    logic [15:0] e;
    logic [6:0]  r;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall    = 1'b0;
        after_hs = 1'b0;
      end else begin
        if (stall) begin
          check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          check("rsp_hold_out", 32'(rsp_out), 32'(stall_out));
          check("rsp_hold_inv", 32'(rsp_invalid), 32'(stall_inv));
        end
        if (after_hs) check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        after_hs = 1'b0;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            r = alsu_fn(e);
            check("rsp_out", 32'(rsp_out), 32'(r[5:0]));
            check("rsp_invalid", 32'(rsp_invalid), 32'(r[6]));
            check("drive_hold", 32'(drive), 32'(e));
          end
          rsp_seen++;
          after_hs = 1'b1;
        end
        stall     = rsp_valid && !rsp_ready;
        stall_out = rsp_out;
        stall_inv = rsp_invalid;
        if (cmd_valid && cmd_ready) exp_q.push_back(cmd_data);
      end
    end
  end

  task automatic send_one(input logic [15:0] c);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_data  = c;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string name, input logic [5:0] eo, input logic ei);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (rsp_valid) found = 1;
      else tick();
    end
    check({name, "_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_out"}, 32'(rsp_out), 32'(eo));
    check({name, "_inv"}, 32'(rsp_invalid), 32'(ei));
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_q.size() == 0 && !rsp_valid) done = 1;
      else tick();
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    tick();
    tick();
  endtask

  initial begin
    int acc;
    int start;
    logic [15:0] c;

    repeat (2) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_out", 32'(rsp_out), 32'd0);
    check("rst_rsp_inv", 32'(rsp_invalid), 32'd0);
    check("rst_drive", 32'(drive), 32'd0);
    rst = 1'b0;
    tick();

    // OR: load on edge 1, response visible after edge 4.
    c = mk(3'd0, 3'd1, 3'd2, 7'd0);
    send_one(c);
    tick();
    check("or_drive_e1", 32'(drive), 32'(c));
    check("or_valid_e1", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    check("or_valid_e3", 32'(rsp_valid), 32'd0);
    tick();
    check("or_valid_e4", 32'(rsp_valid), 32'd1);
    check("or_out", 32'(rsp_out), 32'd3);
    check("or_inv", 32'(rsp_invalid), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("or_valid_e5", 32'(rsp_valid), 32'd0);
    wait_idle();

    // ADD with rsp_ready held high: valid for exactly one cycle.
    send_one(mk(3'd2, 3'd1, 3'd2, 7'b1000000));
    repeat (3) tick();
    check("add_valid_e3", 32'(rsp_valid), 32'd0);
    tick();
    check("add_valid_e4", 32'(rsp_valid), 32'd1);
    check("add_out", 32'(rsp_out), 32'd4);
    tick();
    check("add_valid_e5", 32'(rsp_valid), 32'd0);
    wait_idle();

    // Invalid opcode then MUL.
    send_one(mk(3'd6, 3'd1, 3'd1, 7'd0));
    send_one(mk(3'd3, 3'd2, 3'd3, 7'd0));
    wait_rsp("inv", 6'd0, 1'b1);
    tick();
    wait_rsp("mul", 6'd6, 1'b0);
    tick();
    wait_idle();

    // Backpressure: six back-to-back offers, only five fit.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = 16'($urandom);
      @(negedge clk);
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    check("full_accepted", 32'(acc), 32'd5);
    for (int i = 0; i < 3; i++) begin
      check("full_ready_low", 32'(cmd_ready), 32'd0);
      tick();
    end
    start = rsp_seen;
    rsp_ready = 1'b1;
    for (int i = 0; i < 200 && (rsp_seen - start) < 5; i++) tick();
    check("full_drained", 32'(rsp_seen - start), 32'd5);
    wait_idle();

    // Reset two edges after load: in-flight command is discarded.
    send_one(mk(3'd1, 3'd7, 3'd2, 7'd0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_drive", 32'(drive), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_no_valid", 32'(rsp_valid), 32'd0);
      tick();
    end
    send_one(mk(3'd1, 3'd5, 3'd3, 7'd0));
    wait_rsp("post_rst_xor", 6'd6, 1'b0);
    tick();
    wait_idle();

    // Random traffic with random response backpressure.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_data  = 16'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || rsp_valid); i++) tick();
    check("random_drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
